// File: rtl/uart_block_bridge.sv
// uart_block_bridge
// Byte-to-block bridge between the UART byte engines and a wide block datapath.
//   RX: packs N_BYTES bytes from uart_rx into one block, offered on a
//       valid/ready interface, with overflow flagging and an optional
//       inter-byte timeout that discards a partial block.
//   TX: accepts one block and streams it byte by byte to uart_tx_controller.
// Ports:
//   i_clk, i_reset                     clock, asynchronous active-high reset
//   i_rx_data, i_rx_valid              byte from uart_rx (byte taken on valid rising edge)
//   o_blk_data, o_blk_valid, i_blk_ready   assembled RX block handshake
//   o_rx_overflow, i_clr_flags         sticky dropped-block flag and its clear
//   o_rx_timeout                       one-cycle pulse when a partial block is discarded
//   i_tx_blk, i_tx_blk_valid, o_tx_blk_ready   block to transmit handshake
//   o_tx_byte, o_tx_byte_valid, i_tx_byte_ready   byte stream to uart_tx_controller
module uart_block_bridge #(
    parameter int DATA_W         = 8,
    parameter int N_BYTES        = 16,
    parameter bit MSB_FIRST      = 1'b0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [DATA_W-1:0]         i_rx_data,
    input  logic                      i_rx_valid,
    output logic [DATA_W*N_BYTES-1:0] o_blk_data,
    output logic                      o_blk_valid,
    input  logic                      i_blk_ready,
    output logic                      o_rx_overflow,
    output logic                      o_rx_timeout,
    input  logic                      i_clr_flags,
    input  logic [DATA_W*N_BYTES-1:0] i_tx_blk,
    input  logic                      i_tx_blk_valid,
    output logic                      o_tx_blk_ready,
    output logic [DATA_W-1:0]         o_tx_byte,
    output logic                      o_tx_byte_valid,
    input  logic                      i_tx_byte_ready
);

    localparam int BLK_W   = DATA_W * N_BYTES;
    localparam int CNT_W   = $clog2(N_BYTES);
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int TO_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

    // Byte k of a block lives in slot k (LSB first) or slot N_BYTES-1-k.
    // Both paths use this so an RX->TX loopback preserves byte order.
    function automatic int slot_of(input logic [CNT_W-1:0] k);
        return MSB_FIRST ? int'(LAST_IDX - k) : int'(k);
    endfunction

    // ------------------------------------------------------------------ RX
    logic              rx_valid_q_reg;
    logic [CNT_W-1:0]  rx_cnt_reg;
    logic [BLK_W-1:0]  asm_reg;
    logic [BLK_W-1:0]  asm_next;
    logic [BLK_W-1:0]  blk_data_reg;
    logic              blk_valid_reg;
    logic              overflow_reg;
    logic              timeout_reg;
    logic [TO_W-1:0]   idle_reg;

    logic new_byte;
    logic complete;
    logic can_load;
    logic transfer;
    logic timeout_hit;

    assign new_byte = i_rx_valid & ~rx_valid_q_reg;
    assign complete = new_byte & (rx_cnt_reg == LAST_IDX);
    assign transfer = blk_valid_reg & i_blk_ready;
    // Output register is free if empty or being consumed on this same edge.
    assign can_load = ~blk_valid_reg | i_blk_ready;
    // A byte arriving on the expiry edge takes priority over the timeout.
    assign timeout_hit = TO_EN & ~new_byte & (rx_cnt_reg != '0)
                       & (idle_reg == TO_W'(TO_LAST));

    // Assembly image including the byte arriving this cycle, so the
    // completing byte goes straight into the output register.
    always_comb begin
        asm_next = asm_reg;
        asm_next[slot_of(rx_cnt_reg)*DATA_W +: DATA_W] = i_rx_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_valid_q_reg <= 1'b0;
            rx_cnt_reg     <= '0;
            asm_reg        <= '0;
            blk_data_reg   <= '0;
            blk_valid_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
            idle_reg       <= '0;
        end else begin
            rx_valid_q_reg <= i_rx_valid;
            timeout_reg    <= timeout_hit;

            if (new_byte) begin
                asm_reg    <= asm_next;
                rx_cnt_reg <= (rx_cnt_reg == LAST_IDX) ? '0 : rx_cnt_reg + 1'b1;
                idle_reg   <= '0;
            end else if (timeout_hit) begin
                rx_cnt_reg <= '0;
                idle_reg   <= '0;
            end else if (TO_EN && rx_cnt_reg != '0) begin
                idle_reg   <= idle_reg + 1'b1;
            end

            if (complete && can_load) begin
                blk_data_reg  <= asm_next;
                blk_valid_reg <= 1'b1;
            end else if (transfer) begin
                blk_valid_reg <= 1'b0;
            end

            // Setting wins over clearing on the same edge.
            if (complete && !can_load) begin
                overflow_reg <= 1'b1;
            end else if (i_clr_flags) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign o_blk_data    = blk_data_reg;
    assign o_blk_valid   = blk_valid_reg;
    assign o_rx_overflow = overflow_reg;
    assign o_rx_timeout  = timeout_reg;

    // ------------------------------------------------------------------ TX
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t         state_reg;
    tx_state_t         state_next;
    logic [CNT_W-1:0]  tx_idx_reg;
    logic [CNT_W-1:0]  tx_idx_next;
    logic [BLK_W-1:0]  tx_blk_reg;
    logic [BLK_W-1:0]  tx_blk_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg  <= TX_IDLE;
            tx_idx_reg <= '0;
            tx_blk_reg <= '0;
        end else begin
            state_reg  <= state_next;
            tx_idx_reg <= tx_idx_next;
            tx_blk_reg <= tx_blk_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        tx_idx_next     = tx_idx_reg;
        tx_blk_next     = tx_blk_reg;
        o_tx_byte       = '0;
        o_tx_byte_valid = 1'b0;
        o_tx_blk_ready  = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                o_tx_blk_ready = 1'b1;
                if (i_tx_blk_valid) begin
                    tx_blk_next = i_tx_blk;
                    tx_idx_next = '0;
                    state_next  = TX_SEND;
                end
            end
            TX_SEND: begin
                o_tx_byte       = tx_blk_reg[slot_of(tx_idx_reg)*DATA_W +: DATA_W];
                o_tx_byte_valid = 1'b1;
                if (i_tx_byte_ready) begin
                    if (tx_idx_reg == LAST_IDX) begin
                        tx_idx_next = '0;
                        state_next  = TX_IDLE;
                    end else begin
                        tx_idx_next = tx_idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_block_bridge.sv
// Bench for uart_block_bridge: two instances share all stimulus.
//   u0: MSB_FIRST=0, TIMEOUT_CYCLES=100
//   u1: MSB_FIRST=1, TIMEOUT_CYCLES=0 (timeout disabled)
// Expected blocks/bytes are queued at stimulus time; a monitor pops and
// compares whenever a block or byte handshake completes.
module tb_uart_block_bridge;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         blk_ready;
    logic         clr_flags;
    logic [127:0] tx_blk;
    logic         tx_blk_valid;
    logic         tx_byte_ready;

    logic [127:0] blk_data0, blk_data1;
    logic         blk_valid0, blk_valid1;
    logic         ovf0, ovf1;
    logic         to0, to1;
    logic         tx_blk_ready0, tx_blk_ready1;
    logic [7:0]   tx_byte0, tx_byte1;
    logic         tx_byte_valid0, tx_byte_valid1;

    uart_block_bridge #(.DATA_W(8), .N_BYTES(16), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(100)) u0 (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_blk_data(blk_data0), .o_blk_valid(blk_valid0), .i_blk_ready(blk_ready),
        .o_rx_overflow(ovf0), .o_rx_timeout(to0), .i_clr_flags(clr_flags),
        .i_tx_blk(tx_blk), .i_tx_blk_valid(tx_blk_valid), .o_tx_blk_ready(tx_blk_ready0),
        .o_tx_byte(tx_byte0), .o_tx_byte_valid(tx_byte_valid0), .i_tx_byte_ready(tx_byte_ready)
    );

    uart_block_bridge #(.DATA_W(8), .N_BYTES(16), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(0)) u1 (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_blk_data(blk_data1), .o_blk_valid(blk_valid1), .i_blk_ready(blk_ready),
        .o_rx_overflow(ovf1), .o_rx_timeout(to1), .i_clr_flags(clr_flags),
        .i_tx_blk(tx_blk), .i_tx_blk_valid(tx_blk_valid), .o_tx_blk_ready(tx_blk_ready1),
        .o_tx_byte(tx_byte1), .o_tx_byte_valid(tx_byte_valid1), .i_tx_byte_ready(tx_byte_ready)
    );

    int total = 0;
    int bad   = 0;
    int to_cnt0 = 0;
    int to_cnt1 = 0;

    logic [127:0] blk_q0[$];
    logic [127:0] blk_q1[$];
    logic [7:0]   byte_q0[$];
    logic [7:0]   byte_q1[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic extra(input string name, input logic [127:0] act);
        total++;
        bad++;
        $display("FAIL %s: got unexpected %h required nothing", name, act);
    endtask

    // Block whose byte k is first+k, placed according to the byte-order mode.
    function automatic logic [127:0] blk_of(input logic [7:0] first, input bit msb);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[(msb ? 15 - k : k)*8 +: 8] = first + 8'(k);
        return v;
    endfunction

    // ---------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (blk_valid0 && blk_ready) begin
                if (blk_q0.size() == 0) extra("blk0", blk_data0);
                else check("blk0", blk_data0, blk_q0.pop_front());
            end
            if (blk_valid1 && blk_ready) begin
                if (blk_q1.size() == 0) extra("blk1", blk_data1);
                else check("blk1", blk_data1, blk_q1.pop_front());
            end
            if (tx_byte_valid0) begin
                check("txrdy0_busy", 128'(tx_blk_ready0), 128'd0);
                if (tx_byte_ready) begin
                    if (byte_q0.size() == 0) extra("txbyte0", 128'(tx_byte0));
                    else check("txbyte0", 128'(tx_byte0), 128'(byte_q0.pop_front()));
                end
            end
            if (tx_byte_valid1) begin
                check("txrdy1_busy", 128'(tx_blk_ready1), 128'd0);
                if (tx_byte_ready) begin
                    if (byte_q1.size() == 0) extra("txbyte1", 128'(tx_byte1));
                    else check("txbyte1", 128'(tx_byte1), 128'(byte_q1.pop_front()));
                end
            end
            if (to0) to_cnt0++;
            if (to1) to_cnt1++;
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((blk_q0.size() + blk_q1.size() + byte_q0.size() + byte_q1.size()) != 0 && c < 300) begin
            tick();
            c++;
        end
        total++;
        if (c >= 300) begin
            bad++;
            $display("FAIL %s: %0d expected items left, required 0", name,
                     blk_q0.size() + blk_q1.size() + byte_q0.size() + byte_q1.size());
            blk_q0.delete(); blk_q1.delete(); byte_q0.delete(); byte_q1.delete();
        end else begin
            $display("ok   %s: drained", name);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_blkdata0"}, blk_data0, 128'd0);
        check({tag, "_blkdata1"}, blk_data1, 128'd0);
        check({tag, "_blkvalid0"}, 128'(blk_valid0), 128'd0);
        check({tag, "_blkvalid1"}, 128'(blk_valid1), 128'd0);
        check({tag, "_ovf0"}, 128'(ovf0), 128'd0);
        check({tag, "_ovf1"}, 128'(ovf1), 128'd0);
        check({tag, "_to0"}, 128'(to0), 128'd0);
        check({tag, "_to1"}, 128'(to1), 128'd0);
        check({tag, "_txbyte0"}, 128'(tx_byte0), 128'd0);
        check({tag, "_txbyte1"}, 128'(tx_byte1), 128'd0);
        check({tag, "_txvalid0"}, 128'(tx_byte_valid0), 128'd0);
        check({tag, "_txvalid1"}, 128'(tx_byte_valid1), 128'd0);
        check({tag, "_txrdy0"}, 128'(tx_blk_ready0), 128'd1);
        check({tag, "_txrdy1"}, 128'(tx_blk_ready1), 128'd1);
    endtask

    task automatic run_tx(input logic [127:0] blk, input bit toggle, input string name);
        int c;
        for (int k = 0; k < 16; k++) begin
            byte_q0.push_back(blk[k*8 +: 8]);
            byte_q1.push_back(blk[(15-k)*8 +: 8]);
        end
        tx_blk       = blk;
        tx_blk_valid = 1'b1;
        tick();
        tx_blk_valid = 1'b0;
        tx_blk       = ~blk;   // must not disturb the latched block
        c = 0;
        while ((byte_q0.size() + byte_q1.size()) != 0 && c < 200) begin
            if (toggle) tx_byte_ready = ~tx_byte_ready;
            tick();
            c++;
        end
        tx_byte_ready = 1'b1;
        @(negedge clk);
        check({name, "_done_rdy0"}, 128'(tx_blk_ready0), 128'd1);
        check({name, "_done_rdy1"}, 128'(tx_blk_ready1), 128'd1);
        check({name, "_left"}, 128'(byte_q0.size() + byte_q1.size()), 128'd0);
        byte_q0.delete();
        byte_q1.delete();
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; blk_ready = 1'b1; clr_flags = 1'b0;
        tx_blk = '0; tx_blk_valid = 1'b0; tx_byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        tick();
        rst = 1'b0;
        tick();

        // 1: stream 0x00..0x0F, consumer always ready
        blk_q0.push_back(128'h0F0E0D0C_0B0A0908_07060504_03020100);
        blk_q1.push_back(128'h00010203_04050607_08090A0B_0C0D0E0F);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        drain("t1_drain");
        @(negedge clk);
        check("t1_ovf0", 128'(ovf0), 128'd0);
        check("t1_ovf1", 128'(ovf1), 128'd0);

        // 2: block 0x00..0x0F (MSB-first image) into TX, ready held high
        run_tx(128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0, "t2");

        // 3: overflow with consumer stalled, clear, then accept on completion edge
        tick();
        blk_ready = 1'b0;
        blk_q0.push_back(blk_of(8'h20, 1'b0));
        blk_q1.push_back(blk_of(8'h20, 1'b1));
        for (int i = 0; i < 32; i++) send_byte(8'h20 + 8'(i));
        @(negedge clk);
        check("t3_ovf0", 128'(ovf0), 128'd1);
        check("t3_ovf1", 128'(ovf1), 128'd1);
        check("t3_held0", blk_data0, blk_of(8'h20, 1'b0));
        check("t3_held1", blk_data1, blk_of(8'h20, 1'b1));
        tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        @(negedge clk);
        check("t3_clr0", 128'(ovf0), 128'd0);
        check("t3_clr1", 128'(ovf1), 128'd0);
        tick();
        blk_q0.push_back(blk_of(8'h40, 1'b0));
        blk_q1.push_back(blk_of(8'h40, 1'b1));
        for (int i = 0; i < 15; i++) send_byte(8'h40 + 8'(i));
        rx_data   = 8'h4F;
        rx_valid  = 1'b1;
        blk_ready = 1'b1;
        tick();
        rx_valid  = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t3_noovf0", 128'(ovf0), 128'd0);
        check("t3_noovf1", 128'(ovf1), 128'd0);
        drain("t3_drain");

        // 4: partial block of 5 bytes then idle; u0 times out after 100 cycles
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
        repeat (98) tick();
        check("t4_early_to0", 128'(to_cnt0), 128'd0);
        repeat (12) tick();
        check("t4_to0", 128'(to_cnt0), 128'd1);
        check("t4_to1", 128'(to_cnt1), 128'd0);
        blk_q0.push_back(blk_of(8'h60, 1'b0));
        blk_q1.push_back(128'h50515253_54606162_63646566_6768696A);
        for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
        drain("t4_drain");

        // 5: TX with byte ready toggling every cycle
        tick();
        run_tx(128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b1, "t5");

        // 6: reset mid RX block and mid TX block
        tick();
        for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i));
        tx_blk       = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
        tx_blk_valid = 1'b1;
        tick();
        tx_blk_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            byte_q0.push_back(tx_blk[k*8 +: 8]);
            byte_q1.push_back(tx_blk[(15-k)*8 +: 8]);
        end
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst1");
        check("t6_txleft", 128'(byte_q0.size() + byte_q1.size()), 128'd0);
        byte_q0.delete();
        byte_q1.delete();
        tick();
        rst = 1'b0;
        tick();
        blk_q0.push_back(blk_of(8'h80, 1'b0));
        blk_q1.push_back(blk_of(8'h80, 1'b1));
        for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
        drain("t6_drain");
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
